// File: rtl/riscv_test_monitor.sv
// Test-harness monitor for a RISC-V core: runs until the core parks on a
// "jal x0,0" self-loop, then compares selected registers against expected values.
module riscv_test_monitor #(
  parameter int XLEN           = 32,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HALT_REPEAT    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       retire,
  input  logic [XLEN-1:0]            pc,
  input  logic [31:0]                instr,
  input  logic [NUM_CHECKS*5-1:0]    exp_addr,
  input  logic [NUM_CHECKS*XLEN-1:0] exp_data,
  output logic [4:0]                 rf_addr,
  input  logic [XLEN-1:0]            rf_data,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [$clog2(NUM_CHECKS):0] fail_idx,
  output logic [XLEN-1:0]            got_data,
  output logic [31:0]                cycle_cnt,
  output logic [31:0]                retire_cnt
);

  localparam int IW    = $clog2(NUM_CHECKS) + 1;
  localparam int DEPTH = 1 << IW;
  localparam int HW    = $clog2(HALT_REPEAT + 1);

  localparam logic [31:0]   JAL_SELF    = 32'h0000_006F;
  localparam logic [31:0]   TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  localparam logic [HW-1:0] HALT_LIM    = HW'(HALT_REPEAT);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_CHECKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t          state;
  logic [HW-1:0]   halt_cnt;
  logic [HW-1:0]   halt_nxt;
  logic [XLEN-1:0] last_pc;
  logic [IW-1:0]   check_idx;
  logic [31:0]     cycle_inc;
  logic [31:0]     retire_inc;
  logic            halt_hit;

  // Expected pairs padded to a power of two so check_idx indexes them directly.
  logic [4:0]      addr_tab [DEPTH];
  logic [XLEN-1:0] data_tab [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_tab
    if (g < NUM_CHECKS) begin : g_used
      assign addr_tab[g] = exp_addr[5*g +: 5];
      assign data_tab[g] = exp_data[XLEN*g +: XLEN];
    end else begin : g_pad
      assign addr_tab[g] = '0;
      assign data_tab[g] = '0;
    end
  end

  assign rf_addr = (state == S_CHECK) ? addr_tab[check_idx] : 5'd0;

  // A self-loop only counts when it repeats the previous self-loop's pc.
  always_comb begin
    halt_nxt = halt_cnt;
    if (retire) begin
      if (instr == JAL_SELF)
        halt_nxt = (halt_cnt != '0 && pc == last_pc) ? halt_cnt + 1'b1 : HW'(1);
      else
        halt_nxt = '0;
    end
  end

  assign halt_hit   = (halt_nxt == HALT_LIM);
  assign cycle_inc  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 32'd1;
  assign retire_inc = (retire && retire_cnt != '1) ? retire_cnt + 32'd1 : retire_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      halt_cnt   <= '0;
      last_pc    <= '0;
      check_idx  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_idx   <= '0;
      got_data   <= '0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_RUN;
            halt_cnt   <= '0;
            last_pc    <= '0;
            check_idx  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            fail_idx   <= '0;
            got_data   <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
          end
        end
        S_RUN: begin
          cycle_cnt  <= cycle_inc;
          retire_cnt <= retire_inc;
          halt_cnt   <= halt_nxt;
          if (retire && instr == JAL_SELF)
            last_pc <= pc;
          // Halt takes priority over a timeout landing on the same cycle.
          if (halt_hit) begin
            state     <= S_CHECK;
            check_idx <= '0;
          end else if (cycle_inc == TIMEOUT_LIM) begin
            state   <= S_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
            fail    <= 1'b1;
          end
        end
        S_CHECK: begin
          if (rf_data != data_tab[check_idx]) begin
            state    <= S_DONE;
            done     <= 1'b1;
            fail     <= 1'b1;
            fail_idx <= check_idx;
            got_data <= rf_data;
          end else if (check_idx == LAST_IDX) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            check_idx <= check_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Randomized bench for riscv_test_monitor: expected outcomes come from a
// retirement-list model (halt window, first mismatching pair, timeout bound).
module tb_riscv_test_monitor;

  localparam int          NUM_CHECKS  = 4;
  localparam int          HALT_REPEAT = 3;
  localparam int          T_A         = 200;
  localparam int          T_B         = 20;
  localparam logic [31:0] JAL         = 32'h0000_006F;

  logic        clk = 1'b0;
  logic        rst_n, start_a, start_b, retire;
  logic [31:0] pc, instr;
  logic [19:0] exp_addr;
  logic [127:0] exp_data;

  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        done_a, pass_a, fail_a, timeout_a;
  logic        done_b, pass_b, fail_b, timeout_b;
  logic [2:0]  fail_idx_a, fail_idx_b;
  logic [31:0] got_a, got_b, cyc_a, cyc_b, ret_a, ret_b;

  logic [31:0] rf [32];
  logic [4:0]  ea [NUM_CHECKS];
  logic [31:0] ed [NUM_CHECKS];

  logic        cyc_ret[$];
  logic [31:0] cyc_pc[$];
  logic [31:0] cyc_instr[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic        sel;
  logic        m_done, m_pass, m_fail, m_timeout;
  logic [2:0]  m_fidx;
  logic [4:0]  m_rf_addr;
  logic [31:0] m_got, m_cycle, m_retire;

  always #5 clk = ~clk;

  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  assign m_done    = sel ? done_b     : done_a;
  assign m_pass    = sel ? pass_b     : pass_a;
  assign m_fail    = sel ? fail_b     : fail_a;
  assign m_timeout = sel ? timeout_b  : timeout_a;
  assign m_fidx    = sel ? fail_idx_b : fail_idx_a;
  assign m_rf_addr = sel ? rf_addr_b  : rf_addr_a;
  assign m_got     = sel ? got_b      : got_a;
  assign m_cycle   = sel ? cyc_b      : cyc_a;
  assign m_retire  = sel ? ret_b      : ret_a;

  riscv_test_monitor #(.XLEN(32), .NUM_CHECKS(NUM_CHECKS), .TIMEOUT_CYCLES(T_A),
                       .HALT_REPEAT(HALT_REPEAT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .retire(retire), .pc(pc), .instr(instr),
    .exp_addr(exp_addr), .exp_data(exp_data), .rf_addr(rf_addr_a), .rf_data(rf_data_a),
    .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(timeout_a),
    .fail_idx(fail_idx_a), .got_data(got_a), .cycle_cnt(cyc_a), .retire_cnt(ret_a));

  riscv_test_monitor #(.XLEN(32), .NUM_CHECKS(NUM_CHECKS), .TIMEOUT_CYCLES(T_B),
                       .HALT_REPEAT(HALT_REPEAT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .retire(retire), .pc(pc), .instr(instr),
    .exp_addr(exp_addr), .exp_data(exp_data), .rf_addr(rf_addr_b), .rf_data(rf_data_b),
    .done(done_b), .pass(pass_b), .fail(fail_b), .timeout(timeout_b),
    .fail_idx(fail_idx_b), .got_data(got_b), .cycle_cnt(cyc_b), .retire_cnt(ret_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if (r == JAL) r = 32'h0000_0013;
    return r;
  endfunction

  task automatic clear_prog();
    cyc_ret.delete();
    cyc_pc.delete();
    cyc_instr.delete();
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_ret.push_back(1'b0);
      cyc_pc.push_back(32'd0);
      cyc_instr.push_back(32'd0);
    end
  endtask

  task automatic add_ret(input logic [31:0] p, input logic [31:0] i);
    cyc_ret.push_back(1'b1);
    cyc_pc.push_back(p);
    cyc_instr.push_back(i);
  endtask

  task automatic add_ret_gap(input logic [31:0] p, input logic [31:0] i);
    add_idle($urandom_range(0, 2));
    add_ret(p, i);
  endtask

  task automatic randomize_rf();
    rf[0] = 32'd0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic build_sum_program();
    clear_prog();
    randomize_rf();
    rf[1] = 32'd55; rf[2] = 32'd11; rf[3] = 32'd55; rf[4] = 32'd11;
    for (int i = 0; i < 4; i++) add_ret_gap(32'(4 * i), rand_instr());
    for (int it = 0; it < 10; it++)
      for (int i = 0; i < 3; i++) add_ret_gap(32'h10 + 32'(4 * i), rand_instr());
    for (int i = 0; i < HALT_REPEAT; i++) add_ret_gap(32'h1C, JAL);
    ea[0] = 5'd3; ea[1] = 5'd1; ea[2] = 5'd2; ea[3] = 5'd4;
    ed[0] = 32'd55; ed[1] = 32'd55; ed[2] = 32'd11; ed[3] = 32'd11;
  endtask

  // Start a run, drive the program, and compare against the model's prediction.
  task automatic run_program(input bit use_b, input bit poke_start, input bit do_reset,
                             input string tag);
    int T, h, end_c, exp_ret, mi, exp_done_c, done_c, rf_err;
    int rc[$];
    bit halted, ok;
    logic [4:0]  exp_rf;
    logic [2:0]  exp_fi;
    logic [31:0] exp_got;

    sel = use_b;
    T   = use_b ? T_B : T_A;
    exp_addr = {ea[3], ea[2], ea[1], ea[0]};
    exp_data = {ed[3], ed[2], ed[1], ed[0]};

    for (int c = 0; c < cyc_ret.size(); c++) if (cyc_ret[c]) rc.push_back(c + 1);
    h = 0;
    for (int j = HALT_REPEAT - 1; j < rc.size(); j++) begin
      if (h == 0) begin
        ok = 1'b1;
        for (int k = j - HALT_REPEAT + 1; k <= j; k++)
          if (cyc_instr[rc[k]-1] !== JAL || cyc_pc[rc[k]-1] !== cyc_pc[rc[j]-1]) ok = 1'b0;
        if (ok) h = rc[j];
      end
    end
    halted = (h != 0) && (h <= T);
    end_c  = halted ? h : T;
    exp_ret = 0;
    foreach (rc[k]) if (rc[k] <= end_c) exp_ret++;
    mi = -1;
    for (int i = 0; i < NUM_CHECKS; i++) if (mi < 0 && rf[ea[i]] !== ed[i]) mi = i;
    exp_done_c = !halted ? T : (mi < 0 ? h + NUM_CHECKS : h + mi + 1);
    exp_fi  = (halted && mi >= 0) ? 3'(mi) : 3'd0;
    exp_got = (halted && mi >= 0) ? rf[ea[mi]] : 32'd0;

    retire = 1'b0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    n_checks++;
    if ({m_done, m_pass, m_fail, m_timeout, m_cycle, m_retire} !== '0) begin
      n_fail++;
      $display("[TB] FAIL %s start_clear: got flags=%b cyc=%0d ret=%0d, want all zero",
               tag, {m_done, m_pass, m_fail, m_timeout}, m_cycle, m_retire);
    end

    done_c = 0;
    rf_err = 0;
    for (int c = 1; c <= exp_done_c + 30 && done_c == 0; c++) begin
      if (c <= cyc_ret.size()) begin
        retire = cyc_ret[c-1]; pc = cyc_pc[c-1]; instr = cyc_instr[c-1];
      end else begin
        retire = 1'b0; pc = 32'd0; instr = rand_instr();
      end
      if (poke_start && (c == 2 || (halted && c == h + 1))) begin
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
      end
      tick();
      start_a = 1'b0; start_b = 1'b0;
      exp_rf = 5'd0;
      if (halted && c >= h && c < exp_done_c) exp_rf = ea[c - h];
      if (m_rf_addr !== exp_rf) begin
        if (rf_err == 0)
          $display("[TB] FAIL %s rf_addr at cycle %0d: got %0d want %0d", tag, c, m_rf_addr, exp_rf);
        rf_err++;
      end
      if (do_reset && halted && c == h + 1) begin
        rst_n = 1'b0;
        retire = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({m_done, m_pass, m_fail, m_timeout, m_fidx, m_got, m_cycle, m_retire, m_rf_addr} !== '0) begin
          n_fail++;
          $display("[TB] FAIL %s reset_mid_check: flags=%b fidx=%0d got=%0h cyc=%0d ret=%0d rf_addr=%0d want all zero",
                   tag, {m_done, m_pass, m_fail, m_timeout}, m_fidx, m_got, m_cycle, m_retire, m_rf_addr);
        end
        return;
      end
      if (m_done === 1'b1) done_c = c;
    end
    n_checks++;
    if (rf_err != 0) begin
      n_fail++;
      $display("[TB] FAIL %s rf_addr_trace: %0d wrong samples, want 0", tag, rf_err);
    end
    n_checks++;
    if (done_c != exp_done_c) begin
      n_fail++;
      $display("[TB] FAIL %s done_cycle: got %0d want %0d", tag, done_c, exp_done_c);
    end

    // Outputs must hold in DONE while the core keeps retiring.
    for (int i = 0; i < 3; i++) begin
      retire = 1'b1; pc = $urandom; instr = (i == 0) ? JAL : rand_instr();
      tick();
    end
    retire = 1'b0;
    n_checks++;
    if ({m_done, m_pass, m_fail, m_timeout} !== {1'b1, halted && mi < 0, !(halted && mi < 0), !halted}) begin
      n_fail++;
      $display("[TB] FAIL %s flags(done,pass,fail,timeout): got %b want %b", tag,
               {m_done, m_pass, m_fail, m_timeout}, {1'b1, halted && mi < 0, !(halted && mi < 0), !halted});
    end
    n_checks++;
    if (m_fidx !== exp_fi || m_got !== exp_got) begin
      n_fail++;
      $display("[TB] FAIL %s fail_idx/got_data: got %0d/%0h want %0d/%0h", tag, m_fidx, m_got, exp_fi, exp_got);
    end
    n_checks++;
    if (m_cycle !== 32'(end_c) || m_retire !== 32'(exp_ret)) begin
      n_fail++;
      $display("[TB] FAIL %s counters(cycle,retire): got %0d/%0d want %0d/%0d", tag, m_cycle, m_retire, end_c, exp_ret);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; retire = 1'b0; pc = '0; instr = '0;
    exp_addr = '0; exp_data = '0; sel = 1'b0;
    randomize_rf();
    repeat (3) tick();
    n_checks++;
    if ({done_a, pass_a, fail_a, timeout_a} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b want 0000", {done_a, pass_a, fail_a, timeout_a});
    end
    n_checks++;
    if (fail_idx_a !== 3'd0 || got_a !== 32'd0 || rf_addr_a !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: fidx=%0d got=%0h rf_addr=%0d want 0", fail_idx_a, got_a, rf_addr_a);
    end
    n_checks++;
    if (cyc_a !== 32'd0 || ret_a !== 32'd0 || done_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_counters: cyc=%0d ret=%0d done_b=%b want 0", cyc_a, ret_a, done_b);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      retire = 1'b1; pc = 32'h1C; instr = JAL;
      tick();
    end
    retire = 1'b0;
    n_checks++;
    if (cyc_a !== 32'd0 || ret_a !== 32'd0 || done_a !== 1'b0 || rf_addr_a !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL idle_no_start: cyc=%0d ret=%0d done=%b rf_addr=%0d want 0", cyc_a, ret_a, done_a, rf_addr_a);
    end
  endtask

  task automatic test_sum_pass();
    build_sum_program();
    run_program(1'b0, 1'b0, 1'b0, "sum_pass");
  endtask

  task automatic test_sum_fail();
    build_sum_program();
    ed[0] = 32'd56;
    run_program(1'b0, 1'b0, 1'b0, "sum_fail");
  endtask

  task automatic test_timeout();
    clear_prog();
    while (cyc_ret.size() < 30) add_ret_gap({$urandom_range(0, 255), 2'b00}, rand_instr());
    run_program(1'b1, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_halt_restart();
    clear_prog();
    randomize_rf();
    for (int i = 0; i < 3; i++) add_ret_gap(32'(8 + 4 * i), rand_instr());
    add_ret_gap(32'h40, JAL);
    add_ret_gap(32'h40, JAL);
    add_ret_gap(32'h40, rand_instr());
    for (int i = 0; i < HALT_REPEAT; i++) add_ret_gap(32'h40, JAL);
    for (int i = 0; i < NUM_CHECKS; i++) begin
      ea[i] = 5'($urandom_range(1, 31));
      ed[i] = rf[ea[i]];
    end
    run_program(1'b0, 1'b0, 1'b0, "halt_restart");
  endtask

  // Third self-loop lands exactly on the timeout cycle, then one cycle late.
  task automatic test_halt_at_timeout();
    for (int late = 0; late < 2; late++) begin
      clear_prog();
      randomize_rf();
      for (int c = 0; c < T_B - HALT_REPEAT + late; c++) begin
        if ($urandom_range(0, 1) == 1) add_ret({$urandom_range(0, 255), 2'b00}, rand_instr());
        else add_idle(1);
      end
      for (int i = 0; i < HALT_REPEAT; i++) add_ret(32'h80, JAL);
      for (int i = 0; i < NUM_CHECKS; i++) begin
        ea[i] = 5'($urandom_range(1, 31));
        ed[i] = rf[ea[i]];
      end
      run_program(1'b1, 1'b0, 1'b0, late == 0 ? "halt_at_timeout" : "halt_after_timeout");
    end
  endtask

  task automatic test_start_ignored();
    build_sum_program();
    run_program(1'b0, 1'b1, 1'b0, "start_ignored");
  endtask

  task automatic test_reset_mid_check();
    build_sum_program();
    run_program(1'b0, 1'b0, 1'b1, "reset_mid_check");
    run_program(1'b0, 1'b0, 1'b0, "rerun_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] hp;
    int bad;
    for (int it = 0; it < 6; it++) begin
      clear_prog();
      randomize_rf();
      hp = {$urandom_range(0, 255), 2'b00};
      for (int i = 0; i < $urandom_range(5, 15); i++) begin
        if ($urandom_range(0, 4) == 0) add_ret_gap(hp, JAL);
        else add_ret_gap({$urandom_range(0, 255), 2'b00}, rand_instr());
      end
      add_ret_gap(32'h4, rand_instr());
      for (int i = 0; i < HALT_REPEAT; i++) add_ret_gap(hp, JAL);
      for (int i = 0; i < NUM_CHECKS; i++) begin
        ea[i] = 5'($urandom_range(1, 31));
        ed[i] = rf[ea[i]];
      end
      if ($urandom_range(0, 1) == 1) begin
        bad = $urandom_range(0, NUM_CHECKS - 1);
        ed[bad] = ed[bad] ^ (32'd1 << $urandom_range(0, 31));
      end
      run_program(1'b0, 1'($urandom_range(0, 1)), 1'b0, $sformatf("random_%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_sum_pass();
    test_sum_fail();
    test_timeout();
    test_halt_restart();
    test_halt_at_timeout();
    test_start_ignored();
    test_reset_mid_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
